// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ word sources.
// Each grant sends an optional {4'hA, id} header byte, then the latched word MSB first.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_BYTES = 4,
  parameter bit          HEADER_EN  = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*8*WORD_BYTES-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [7:0]                      tx_byte,
  output logic                            tx_start,
  input  logic                            tx_busy,
  output logic                            grant_valid,
  output logic [3:0]                      grant_id
);

  localparam int unsigned W          = 8 * WORD_BYTES;
  localparam int unsigned IdW        = $clog2(NUM_REQ);
  localparam int unsigned TotalBytes = WORD_BYTES + (HEADER_EN ? 1 : 0);
  localparam int unsigned CntW       = $clog2(TotalBytes + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StStart,
    StWaitBusy,
    StWaitDone,
    StAck
  } state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_q, gid_q, pick_id;
  logic            pick_found;
  logic [IdW:0]    scan_idx;
  logic [W-1:0]    shreg_q;
  logic [CntW-1:0] cnt_q;
  logic            tx_start_q;
  logic            hdr_byte;
  logic [7:0]      cur_byte;

  // First pending requester at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      scan_idx = {1'b0, rr_q} + (IdW + 1)'(j);
      if (scan_idx >= (IdW + 1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (IdW + 1)'(NUM_REQ);
      end
      if (!pick_found && req[scan_idx[IdW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx[IdW-1:0];
      end
    end
  end

  // The header goes out while the byte counter still holds the full packet length.
  assign hdr_byte = HEADER_EN && (cnt_q == CntW'(TotalBytes));
  assign cur_byte = hdr_byte ? {4'hA, grant_id} : shreg_q[W-1 -: 8];
  assign grant_id = 4'(gid_q);
  assign tx_start = tx_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      gid_q      <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= (state_q == StStart) && !tx_busy;
      case (state_q)
        StIdle: begin
          if (pick_found) gid_q <= pick_id;
        end
        StLatch: begin
          shreg_q <= req_data[gid_q * W +: W];
          cnt_q   <= CntW'(TotalBytes);
        end
        StWaitDone: begin
          if (!tx_busy) begin
            if (!hdr_byte) shreg_q <= shreg_q << 8;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAck: begin
          rr_q <= (gid_q == IdW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (pick_found) state_d = StLatch;
      StLatch:    state_d = StStart;
      StStart:    if (!tx_busy) state_d = StWaitBusy;
      StWaitBusy: if (tx_busy) state_d = StWaitDone;
      StWaitDone: begin
        if (!tx_busy) state_d = (cnt_q == CntW'(1)) ? StAck : StStart;
      end
      StAck:      state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_valid = 1'b0;
    req_ack     = '0;
    tx_byte     = '0;
    case (state_q)
      StLatch: grant_valid = 1'b1;
      StStart, StWaitBusy, StWaitDone: begin
        grant_valid = 1'b1;
        tx_byte     = cur_byte;
      end
      StAck:   req_ack[gid_q] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a busy-flag UART stand-in, random requesters and
// a packet-level round-robin model that predicts grant order, line bytes and acks.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ack;
  logic [7:0]      tx_byte;
  logic            tx_start;
  logic            tx_busy;
  logic            grant_valid;
  logic [3:0]      grant_id;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .WORD_BYTES (4),
    .HEADER_EN  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_byte     (tx_byte),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         model_rr = 0;
  int         ack_exp = -1;
  int         ack_count = 0;
  int         start_count = 0;
  logic [31:0] word_m [NR];
  bit         drop_wait [NR];
  logic [7:0] byte_q [$];
  logic [7:0] seen_bytes [$];
  int         grant_log [$];
  logic [7:0] last_byte;
  bit         byte_pending = 1'b0;
  logic [NR-1:0] prev_req = '0;
  bit         prev_gv = 1'b0;

  // Stimulus control and UART stand-in state
  bit rand_en = 1'b0, drop_en = 1'b0, spurt_en = 1'b0, force_busy = 1'b0;
  bit start_pend = 1'b0;
  int start_dly = 0, busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    byte_q.delete();
    ack_exp      = -1;
    model_rr     = 0;
    byte_pending = 1'b0;
    for (int i = 0; i < NR; i++) drop_wait[i] = 1'b0;
  endtask

  task automatic raise(input int i, input logic [31:0] w);
    word_m[i]          = w;
    req_data[i*W +: W] = w;
    req[i]             = 1'b1;
  endtask

  // One clock of stimulus: UART busy behaviour, then requester behaviour.
  task automatic step();
    @(posedge clk);
    #1;
    if (!force_busy) begin
      if (start_pend) begin
        if (start_dly == 0) begin
          tx_busy    = 1'b1;
          busy_cnt   = $urandom_range(2, 10);
          start_pend = 1'b0;
        end else begin
          start_dly--;
        end
      end else if (tx_busy) begin
        if (busy_cnt == 0) tx_busy = 1'b0;
        else busy_cnt--;
      end else if (spurt_en && !grant_valid && $urandom_range(0, 7) == 0) begin
        tx_busy  = 1'b1;
        busy_cnt = $urandom_range(2, 12);
      end
      if (tx_start) begin
        start_pend = 1'b1;
        start_dly  = $urandom_range(0, 2);
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_ack[i]) begin
        req[i]       = 1'b0;
        drop_wait[i] = 1'b0;
      end else if (drop_en && req[i] && grant_valid && grant_id == 4'(i)
                   && $urandom_range(0, 15) == 0) begin
        req[i]       = 1'b0;
        drop_wait[i] = 1'b1;
      end else if (rand_en && !req[i] && !drop_wait[i] && $urandom_range(0, 3) == 0) begin
        raise(i, $urandom);
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (ack_count < target && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(ack_count >= target), 32'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_grant_valid"}, 32'(grant_valid), 32'd0);
    chk({name, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({name, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({name, "_tx_byte"}, 32'(tx_byte), 32'd0);
    chk({name, "_req_ack"}, 32'(req_ack), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst");
    clear_model();
    run(2);
    rst_n = 1'b1;
  endtask

  // Monitor: predicts each packet at grant time and checks bytes and acks as they appear.
  always @(negedge clk) begin : monitor
    int k;
    int idx;
    if (rst_n) begin
      if (grant_valid && !prev_gv) begin
        k = -1;
        for (int j = 0; j < NR; j++) begin
          idx = (model_rr + j) % NR;
          if (k < 0 && prev_req[idx]) k = idx;
        end
        if (ack_exp >= 0) chk("grant_overlap", 32'(ack_exp), 32'hFFFF_FFFF);
        if (k < 0) begin
          chk("grant_without_req", 32'(prev_req), 32'd1);
        end else begin
          chk("grant_id", 32'(grant_id), 32'(k));
          byte_q.push_back(8'hA0 | 8'(k));
          for (int b = 3; b >= 0; b--) byte_q.push_back(word_m[k][b*8 +: 8]);
          ack_exp = k;
          grant_log.push_back(k);
        end
      end
      if (tx_start) begin
        chk("start_while_busy", 32'(tx_busy), 32'd0);
        start_count++;
        seen_bytes.push_back(tx_byte);
        if (byte_q.size() == 0) chk("unexpected_start", 32'(tx_byte), 32'hFFFF_FFFF);
        else chk("tx_byte", 32'(tx_byte), 32'(byte_q.pop_front()));
        last_byte    = tx_byte;
        byte_pending = 1'b1;
      end else if (byte_pending && tx_busy) begin
        chk("byte_stable", 32'(tx_byte), 32'(last_byte));
        byte_pending = 1'b0;
      end
      if (req_ack != '0) begin
        if (ack_exp < 0) begin
          chk("unexpected_ack", 32'(req_ack), 32'd0);
        end else begin
          chk("req_ack", 32'(req_ack), 32'd1 << ack_exp);
          chk("bytes_left_at_ack", 32'(byte_q.size()), 32'd0);
          chk("grant_valid_at_ack", 32'(grant_valid), 32'd0);
          model_rr = (ack_exp + 1) % NR;
          ack_exp  = -1;
          ack_count++;
        end
      end
    end
    prev_gv  = grant_valid;
    prev_req = req;
  end

  initial begin : main
    logic [7:0] exp1 [5];
    int sc;
    int n;
    exp1 = '{8'hA0, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Single requester, fixed word
    seen_bytes.delete();
    raise(0, 32'hDEADBEEF);
    wait_acks(1, 2000, "p1_timeout");
    chk("p1_nbytes", 32'(seen_bytes.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < seen_bytes.size()) chk("p1_byte", 32'(seen_bytes[i]), 32'(exp1[i]));
    end
    run(3);

    // Pointer at 2 after serving 1: requesters 0 and 3 together -> 3 first
    grant_log.delete();
    raise(1, $urandom);
    wait_acks(2, 2000, "p3a_timeout");
    run(2);
    raise(0, $urandom);
    raise(3, $urandom);
    wait_acks(4, 4000, "p3b_timeout");
    run(3);
    chk("p3_ngrants", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      chk("p3_g0", 32'(grant_log[0]), 32'd1);
      chk("p3_g1", 32'(grant_log[1]), 32'd3);
      chk("p3_g2", 32'(grant_log[2]), 32'd0);
    end

    // Fresh reset, all four at once -> 0,1,2,3
    pulse_reset();
    grant_log.delete();
    for (int i = 0; i < NR; i++) raise(i, $urandom);
    wait_acks(8, 8000, "p2_timeout");
    run(3);
    chk("p2_ngrants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) chk("p2_order", 32'(grant_log[i]), 32'(i));
    end

    // UART busy at grant: no start until busy falls
    force_busy = 1'b1;
    tx_busy    = 1'b1;
    sc         = start_count;
    raise(2, $urandom);
    run(30);
    chk("busy_hold_start", 32'(start_count), 32'(sc));
    chk("busy_hold_grant", 32'(grant_valid), 32'd1);
    force_busy = 1'b0;
    tx_busy    = 1'b0;
    wait_acks(9, 2000, "p5_timeout");
    chk("p5_bytes", 32'(start_count - sc), 32'd5);

    // Random traffic with mid-packet drops, busy spurts and one mid-byte reset
    rand_en  = 1'b1;
    drop_en  = 1'b1;
    spurt_en = 1'b1;
    run(1500);
    n = 0;
    while (!(grant_valid && tx_busy) && n < 2000) begin
      step();
      n++;
    end
    chk("midbyte_reached", 32'(grant_valid && tx_busy), 32'd1);
    pulse_reset();
    run(1500);

    rand_en  = 1'b0;
    drop_en  = 1'b0;
    spurt_en = 1'b0;
    n = 0;
    while (!(req == '0 && !grant_valid && ack_exp < 0 && !drop_wait[0] && !drop_wait[1]
             && !drop_wait[2] && !drop_wait[3]) && n < 20000) begin
      step();
      n++;
    end
    run(5);
    chk("drain_done", 32'(n < 20000), 32'd1);
    chk("final_queue_empty", 32'(byte_q.size()), 32'd0);
    chk("final_no_outstanding", 32'(ack_exp), 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
